// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, constants and PC helpers for the fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } fetch_state_e;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR        = 32'd4;

    // Wide enough to hold IMEM_LATENCY-1 for latencies 1..4.
    localparam int unsigned LAT_CNT_W = 2;

    // Byte address -> 30-bit word address.
    function automatic logic [29:0] pc_word(input logic [31:0] byte_pc);
        return 30'(byte_pc >> 2);
    endfunction

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] pc_align(input logic [31:0] byte_pc);
        return byte_pc & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_prefetch_buf.sv
// fetch_prefetch_buf: one-entry speculative fetch buffer with in-flight
// tracking. Only built when FETCH_PREFETCH_EN is defined.
`ifdef FETCH_PREFETCH_EN
module fetch_prefetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_i,
    input  logic [31:0] issue_pc_i,
    input  logic        flush_i,
    input  logic        consume_i,
    input  logic [31:0] rdata_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] data_o,
    output logic        inflight_o,
    output logic        land_o
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

    logic                 valid_q, valid_d;
    logic                 inflight_q, inflight_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          data_q, data_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

    // Read data arrives this cycle for the outstanding speculative read.
    assign land_o     = inflight_q && (cnt_q == '0) && !flush_i;
    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign data_o     = data_q;
    assign inflight_o = inflight_q;

    // Buffer next-state: flush beats issue; a landing read consumed in the
    // same cycle is handed straight through and never marked valid.
    always_comb begin
        valid_d    = valid_q;
        inflight_d = inflight_q;
        pc_d       = pc_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        if (flush_i) begin
            valid_d    = 1'b0;
            inflight_d = 1'b0;
        end else if (issue_i) begin
            valid_d    = 1'b0;
            inflight_d = 1'b1;
            pc_d       = issue_pc_i;
            cnt_d      = LAT_LOAD;
        end else if (inflight_q) begin
            if (cnt_q == '0) begin
                inflight_d = 1'b0;
                valid_d    = !consume_i;
                data_d     = rdata_i;
            end else begin
                cnt_d = cnt_q - LAT_CNT_W'(1);
            end
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            inflight_q <= 1'b0;
            pc_q       <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            inflight_q <= inflight_d;
            pc_q       <= pc_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Computes the next PC on each enable
// pulse, reads instruction memory and presents pc/command with a one-cycle
// done pulse. Define FETCH_PREFETCH_EN for a one-entry sequential prefetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = FETCH_RESET_PC,
    parameter int unsigned IMEM_LATENCY = 2,
    parameter int unsigned IMEM_ADDR_W  = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   done,
    output logic [31:0]            pc,
    output logic [31:0]            command,
    output logic                   busy,
    output logic                   imem_en,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(IMEM_LATENCY - 1);

    fetch_state_e           state_q, state_d;
    logic                   first_q, first_d;
    logic [31:0]            fetch_pc_q, fetch_pc_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            cmd_q, cmd_d;
    logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]            next_pc;
    logic                   accept;

    // Hooks shared by both builds: buffer hit, join of an in-flight read,
    // and the condition/PC that ends the WAIT state.
    logic                   pf_hit, pf_join, wait_done;
    logic [31:0]            hit_pc, hit_data, wait_pc;

    assign accept = (state_q == IDLE) && enable;

    // Next fetch address: reset vector once, then redirect target or pc+4.
    always_comb begin
        if (first_q) begin
            next_pc = RESET_PC;
        end else if (redirect) begin
            next_pc = pc_align(redirect_pc);
        end else begin
            next_pc = pc_q + PC_INCR;
        end
    end

`ifdef FETCH_PREFETCH_EN
    logic        pf_seq, pf_valid, pf_inflight, pf_land;
    logic        pf_issue, pf_flush, pf_consume;
    logic [31:0] pf_pc, pf_data;
    logic        pf_wait_q, pf_wait_d;

    // A landing read counts as a hit so the join path can never miss it.
    assign pf_seq     = !first_q && !redirect;
    assign pf_hit     = pf_seq && (pf_valid || pf_land);
    assign pf_join    = pf_seq && !pf_valid && !pf_land && pf_inflight;
    assign hit_pc     = pf_pc;
    assign hit_data   = pf_valid ? pf_data : imem_rdata;
    assign wait_done  = pf_wait_q ? pf_land : (cnt_q == '0);
    assign wait_pc    = pf_wait_q ? pf_pc : fetch_pc_q;
    assign pf_issue   = (state_q == DELIVER);
    assign pf_flush   = accept && !pf_seq;
    assign pf_consume = (accept && pf_hit) || ((state_q == WAIT) && pf_wait_q && pf_land);

    // Track whether WAIT is waiting on the prefetch rather than a demand read.
    always_comb begin
        pf_wait_d = pf_wait_q;
        if (accept) begin
            pf_wait_d = pf_join;
        end else if ((state_q == WAIT) && wait_done) begin
            pf_wait_d = 1'b0;
        end
    end

    // Join flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_wait_q <= 1'b0;
        end else begin
            pf_wait_q <= pf_wait_d;
        end
    end

    fetch_prefetch_buf #(
        .LATENCY (IMEM_LATENCY)
    ) u_pf_buf (
        .clk        (clk),
        .rst        (rst),
        .issue_i    (pf_issue),
        .issue_pc_i (pc_q + PC_INCR),
        .flush_i    (pf_flush),
        .consume_i  (pf_consume),
        .rdata_i    (imem_rdata),
        .valid_o    (pf_valid),
        .pc_o       (pf_pc),
        .data_o     (pf_data),
        .inflight_o (pf_inflight),
        .land_o     (pf_land)
    );
`else
    assign pf_hit    = 1'b0;
    assign pf_join   = 1'b0;
    assign hit_pc    = '0;
    assign hit_data  = '0;
    assign wait_done = (cnt_q == '0);
    assign wait_pc   = fetch_pc_q;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; enable outside IDLE is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (pf_hit) begin
                        state_d = DELIVER;
                    end else if (pf_join) begin
                        state_d = WAIT;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ:     state_d = WAIT;
            WAIT:    if (wait_done) state_d = DELIVER;
            DELIVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        done = (state_q == DELIVER);
        busy = (state_q == REQ) || (state_q == WAIT);
`ifdef FETCH_PREFETCH_EN
        imem_en = (state_q == REQ) || pf_issue;
`else
        imem_en = (state_q == REQ);
`endif
    end

    // Datapath next-state: latch fetch address, count latency, capture data.
    always_comb begin
        first_d    = first_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    first_d = 1'b0;
                    if (pf_hit) begin
                        pc_d  = hit_pc;
                        cmd_d = hit_data;
                    end else if (!pf_join) begin
                        fetch_pc_d = next_pc;
                        addr_d     = IMEM_ADDR_W'(pc_word(next_pc));
                    end
                end
            end
            REQ: cnt_d = LAT_LOAD;
            WAIT: begin
                if (wait_done) begin
                    pc_d  = wait_pc;
                    cmd_d = imem_rdata;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            default: ;
        endcase
`ifdef FETCH_PREFETCH_EN
        // The speculative read is issued in DELIVER, so its address is staged here.
        if (state_d == DELIVER) begin
            addr_d = IMEM_ADDR_W'(pc_word(pc_d + PC_INCR));
        end
`endif
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q    <= 1'b1;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            cmd_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            first_q    <= first_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign command   = cmd_q;
    assign imem_addr = addr_q;

    // An enable pulse during a fetch is dropped; make controller bugs visible.
    assert property (@(posedge clk) disable iff (rst) busy |-> !enable)
        else $warning("fetch_unit: enable pulse arrived while busy and was dropped");

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit (default build).
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned LAT      = 2;
    localparam int unsigned AW       = 15;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic          enable      = 1'b0;
    logic          redirect    = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          done;
    logic [31:0]   pc;
    logic [31:0]   command;
    logic          busy;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    // Reference model state: reset-vector pending flag and last delivered PC.
    bit          m_first = 1'b1;
    logic [31:0] m_pc    = RESET_PC;

    // Observed events, logged once per cycle.
    int unsigned en_cyc[$];
    logic [31:0] en_addr[$];
    int unsigned dn_cyc[$];
    logic [31:0] dn_pc[$];
    logic [31:0] dn_cmd[$];

    fetch_unit #(
        .RESET_PC     (RESET_PC),
        .IMEM_LATENCY (LAT),
        .IMEM_ADDR_W  (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .done        (done),
        .pc          (pc),
        .command     (command),
        .busy        (busy),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents as a function of word address.
    function automatic logic [31:0] mem_word(input int unsigned waddr);
        if (waddr == 0) return 32'h2001_0005;
        return (waddr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory with LAT cycles of read latency; garbage whenever no read lands.
    logic [31:0] rd_pipe [LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= imem_en ? mem_word(32'(imem_addr)) : $urandom;
        for (int unsigned i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign imem_rdata = rd_pipe[LAT-1];

    always @(negedge clk) begin
        if (imem_en) begin
            en_cyc.push_back(cyc);
            en_addr.push_back(32'(imem_addr));
        end
        if (done) begin
            dn_cyc.push_back(cyc);
            dn_pc.push_back(pc);
            dn_cmd.push_back(command);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_log();
        en_cyc.delete();
        en_addr.delete();
        dn_cyc.delete();
        dn_pc.delete();
        dn_cmd.delete();
    endtask

    // One fetch transaction; poke adds a second enable (with redirect) mid-fetch.
    task automatic fetch(input bit redir, input logic [31:0] tgt, input bit poke);
        logic [31:0] exp_pc;
        int unsigned exp_waddr;
        int unsigned t0;
        if (m_first)    exp_pc = RESET_PC;
        else if (redir) exp_pc = tgt - (tgt % 32'd4);
        else            exp_pc = m_pc + 32'd4;
        exp_waddr = (exp_pc / 4) % (32'd1 << AW);

        @(posedge clk); #1;
        clear_log();
        t0          = cyc;
        enable      = 1'b1;
        redirect    = redir;
        redirect_pc = tgt;
        @(posedge clk); #1;
        enable      = 1'b0;
        redirect    = 1'($urandom);
        redirect_pc = $urandom;
        check("busy_in_req", busy, 1'b1);
        if (poke) begin
            @(posedge clk); #1;
            enable      = 1'b1;
            redirect    = 1'b1;
            redirect_pc = $urandom;
            @(posedge clk); #1;
            enable      = 1'b0;
            redirect    = 1'b0;
        end
        repeat (LAT + 6) @(posedge clk);
        #1;

        check("done_count", dn_cyc.size(), 1);
        check("done_latency", dn_cyc.size() > 0 ? dn_cyc[0] - t0 : 'x, LAT + 2);
        check("pc", dn_pc.size() > 0 ? dn_pc[0] : 'x, exp_pc);
        check("command", dn_cmd.size() > 0 ? dn_cmd[0] : 'x, mem_word(exp_waddr));
        check("imem_en_count", en_cyc.size(), 1);
        check("imem_en_cycle", en_cyc.size() > 0 ? en_cyc[0] - t0 : 'x, 1);
        check("imem_addr", en_addr.size() > 0 ? en_addr[0] : 'x, exp_waddr);
        check("busy_after", busy, 1'b0);
        check("pc_hold", pc, exp_pc);

        m_first = 1'b0;
        m_pc    = exp_pc;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_done"}, done, 1'b0);
        check({pfx, "_busy"}, busy, 1'b0);
        check({pfx, "_imem_en"}, imem_en, 1'b0);
        check({pfx, "_imem_addr"}, imem_addr, '0);
        check({pfx, "_pc"}, pc, RESET_PC);
        check({pfx, "_command"}, command, 32'd0);
    endtask

    // Reset two cycles into a fetch: nothing delivered, late data never captured.
    task automatic fetch_then_reset();
        @(posedge clk); #1;
        clear_log();
        enable   = 1'b1;
        redirect = 1'b0;
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        rst    = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        @(posedge clk); #1;
        rst    = 1'b0;
        enable = 1'b0;
        repeat (LAT + 6) @(posedge clk);
        #1;
        check("midrst_no_done", dn_cyc.size(), 0);
        check("midrst_cmd_kept", command, 32'd0);
        check("midrst_pc_kept", pc, RESET_PC);
        m_first = 1'b1;
        m_pc    = RESET_PC;
    endtask

    initial begin
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);

        fetch(1'b0, '0, 1'b0);
        fetch(1'b0, '0, 1'b0);
        fetch(1'b0, '0, 1'b0);
        fetch(1'b1, 32'h0000_0103, 1'b0);
        fetch(1'b0, '0, 1'b0);
        fetch(1'b1, 32'hFFFF_FFFE, 1'b0);
        fetch(1'b0, '0, 1'b0);
        fetch(1'b0, '0, 1'b1);
        fetch_then_reset();
        fetch(1'b1, 32'h0000_0500, 1'b0);
        fetch(1'b0, '0, 1'b0);

        for (int unsigned k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            if ($urandom_range(0, 15) == 0) begin
                fetch_then_reset();
            end else begin
                fetch($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 7) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "tb_fetch_unit watchdog");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage. It is the initiator that feeds the decode stage. On each `enable` pulse from the core controller it computes the next PC, reads the instruction BRAM, and presents `pc`/`command` with a one-cycle `done` pulse. That pulse drives decode's `enable` directly. Sequential PC (+4) or a redirect PC from the branch/jump resolution in execute.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset
IMEM_LATENCY, 2, cycles from imem_en high to imem_rdata valid (1..4)
IMEM_ADDR_W, 15, instruction memory word-address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  one-cycle pulse: fetch next instruction
redirect  in  1  qualifies enable: use redirect_pc instead of pc+4
redirect_pc  in  32  byte-address branch/jump target
done  out  1  one-cycle pulse: pc/command valid
pc  out  32  byte address of delivered instruction
command  out  32  delivered instruction word
busy  out  1  fetch in progress; enable ignored while high
imem_en  out  1  instruction memory read strobe
imem_addr  out  IMEM_ADDR_W  word address = fetch_pc[IMEM_ADDR_W+1:2]
imem_rdata  in  32  instruction memory read data

Behaviour:
- Reset (async, rst=1): state IDLE; done=0, busy=0, imem_en=0, imem_addr=0, pc=RESET_PC, command=0. A `first` flag is set. Reset mid-fetch aborts; late imem_rdata is never captured.
- Next PC:
  - first flag set: RESET_PC, regardless of redirect; the flag clears at that fetch.
  - else if redirect: {redirect_pc[31:2],2'b00}.
  - else: pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- FSM states: IDLE, REQ, WAIT, DELIVER.
  - IDLE: enable sampled at edge t -> REQ; busy=1 from t+1.
  - REQ (cycle t+1): imem_en=1 for exactly one cycle; imem_addr = next-PC word address; latency counter loads IMEM_LATENCY-1.
  - WAIT: counter decrements; imem_rdata is sampled in cycle t+1+IMEM_LATENCY into command, pc <= fetch PC.
  - DELIVER (cycle t+2+IMEM_LATENCY): done=1, busy=0, then IDLE.
  - Default latency: enable at t -> done at t+4.
- enable while busy=1: ignored, no state change. A simulation-only assertion flags it.
- enable and rst together: rst wins.
- pc/command hold their values until the next capture. Decode samples them in the done cycle.
- imem_addr holds its last value when imem_en=0.

Optional Feature:
FETCH_PREFETCH_EN.
- Defined:
  - After each DELIVER, the unit issues one speculative read of pc+4 into a one-entry buffer (buf_valid, buf_pc, buf_data).
  - Next enable without redirect, buffer valid: done is asserted at t+1 with buf_pc/buf_data, and the next prefetch starts.
  - Next enable without redirect, prefetch still in flight: done is asserted the cycle after the data lands.
  - Next enable with redirect: the buffer is invalidated, in-flight data is discarded, and a normal fetch of the target runs.
  - Reset clears buf_valid.
- Undefined: no buffer logic; imem_en is asserted only in REQ.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum (IDLE, REQ, WAIT, DELIVER)
  - RESET_PC default
  - the PC increment constant 4
  - word-address slice helper
- Natural sub-module: fetch_prefetch_buf, the one-entry buffer with valid/discard tracking. It is instantiated only under FETCH_PREFETCH_EN.

Test Plan:
1. Reset, then enable at cycle 10; memory word 0 = 32'h2001_0005 -> imem_en at 11 with imem_addr=0; done at 14 with pc=0, command=32'h2001_0005.
2. Three enables without redirect (each after the previous done) -> pc sequence 0, 4, 8; imem_addr 0, 1, 2.
3. enable with redirect=1, redirect_pc=32'h0000_0103 -> fetch address 32'h100, imem_addr=32'h40, delivered pc=32'h100.
4. redirect to 32'hFFFF_FFFC, then enable without redirect -> next delivered pc=0 (wrap).
5. Second enable pulse at t+2 while busy -> ignored; exactly one done; assertion fires. rst asserted at t+2 of a fetch -> no done, outputs at reset values, next fetch is RESET_PC.
6. FETCH_PREFETCH_EN defined: enable 5 cycles after done -> done one cycle later with pc+4. enable with redirect while prefetch in flight -> stale word is never delivered; the target word is delivered at t+4.
